rps_match_scorer: RTL and testbench



---
 rtl/rps_match_scorer.sv | 160 ++++++++++++++++
 tb/tb_rps_match_scorer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_match_scorer.sv
// Best-of-N match scorer fed by per-round verdict pulses from the round judge.
// Optional macro RPS_HISTORY_EN adds an 8-bit history of the last four scored verdicts.
module rps_match_scorer #(
    parameter int unsigned WINS_TO_MATCH = 3,
    parameter int unsigned MAX_ROUNDS    = 5,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             result_valid,
    input  logic [1:0]       result,
    input  logic             new_match,
    output logic [CNT_W-1:0] p1_score,
    output logic [CNT_W-1:0] p2_score,
    output logic [CNT_W-1:0] tie_count,
    output logic [CNT_W-1:0] round_count,
    output logic [CNT_W-1:0] invalid_count,
    output logic             round_done,
    output logic             match_over,
    output logic [1:0]       match_winner,
    output logic [7:0]       history
);

    localparam logic [CNT_W-1:0] WinsCnt   = CNT_W'(WINS_TO_MATCH);
    localparam logic [CNT_W-1:0] RoundsCnt = CNT_W'(MAX_ROUNDS);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    localparam logic [1:0] ResTie     = 2'b00;
    localparam logic [1:0] ResP1      = 2'b01;
    localparam logic [1:0] ResP2      = 2'b10;
    localparam logic [1:0] ResInvalid = 2'b11;

    typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] p1_q, p1_d, p2_q, p2_d, tie_q, tie_d;
    logic [CNT_W-1:0] round_q, round_d, inv_q, inv_d;
    logic             round_done_q, round_done_d;
    logic             match_over_q, match_over_d;
    logic [1:0]       winner_q, winner_d;

    always_comb begin
        state_d      = state_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        tie_d        = tie_q;
        round_d      = round_q;
        inv_d        = inv_q;
        round_done_d = 1'b0;
        match_over_d = match_over_q;
        winner_d     = winner_q;

        if (new_match) begin
            state_d      = StIdle;
            p1_d         = '0;
            p2_d         = '0;
            tie_d        = '0;
            round_d      = '0;
            inv_d        = '0;
            match_over_d = 1'b0;
            winner_d     = 2'b00;
        end else begin
            case (state_q)
                StIdle, StPlay: begin
                    if (result_valid) begin
                        if (result == ResInvalid) begin
                            if (inv_q != '1) begin
                                inv_d = inv_q + CntOne;
                            end
                        end else begin
                            state_d      = StPlay;
                            round_d      = round_q + CntOne;
                            round_done_d = 1'b1;
                            case (result)
                                ResP1:   p1_d  = p1_q + CntOne;
                                ResP2:   p2_d  = p2_q + CntOne;
                                default: tie_d = tie_q + CntOne;
                            endcase
                            // Outright win beats the round limit on the same edge.
                            if (p1_d == WinsCnt) begin
                                state_d      = StDone;
                                match_over_d = 1'b1;
                                winner_d     = ResP1;
                            end else if (p2_d == WinsCnt) begin
                                state_d      = StDone;
                                match_over_d = 1'b1;
                                winner_d     = ResP2;
                            end else if (round_d == RoundsCnt) begin
                                state_d      = StDone;
                                match_over_d = 1'b1;
                                if (p1_d > p2_d) begin
                                    winner_d = ResP1;
                                end else if (p2_d > p1_d) begin
                                    winner_d = ResP2;
                                end else begin
                                    winner_d = ResTie;
                                end
                            end
                        end
                    end
                end
                StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            p1_q         <= '0;
            p2_q         <= '0;
            tie_q        <= '0;
            round_q      <= '0;
            inv_q        <= '0;
            round_done_q <= 1'b0;
            match_over_q <= 1'b0;
            winner_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            tie_q        <= tie_d;
            round_q      <= round_d;
            inv_q        <= inv_d;
            round_done_q <= round_done_d;
            match_over_q <= match_over_d;
            winner_q     <= winner_d;
        end
    end

    assign p1_score      = p1_q;
    assign p2_score      = p2_q;
    assign tie_count     = tie_q;
    assign round_count   = round_q;
    assign invalid_count = inv_q;
    assign round_done    = round_done_q;
    assign match_over    = match_over_q;
    assign match_winner  = winner_q;

`ifdef RPS_HISTORY_EN
    logic [7:0] history_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_q <= 8'h00;
        end else if (new_match) begin
            history_q <= 8'h00;
        end else if (result_valid && (result != ResInvalid) && (state_q != StDone)) begin
            history_q <= {history_q[5:0], result};
        end
    end

    assign history = history_q;
`else
    assign history = 8'h00;
`endif

endmodule

// File: tb/tb_rps_match_scorer.sv
// Self-checking bench for rps_match_scorer: directed scenarios plus random traffic
// compared against a round-by-round behavioural match model.
module tb_rps_match_scorer;

    localparam int WINS = 3;
    localparam int MAXR = 5;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          result_valid;
    logic [1:0]    result;
    logic          new_match;
    logic [CW-1:0] p1_score, p2_score, tie_count, round_count, invalid_count;
    logic          round_done, match_over;
    logic [1:0]    match_winner;
    logic [7:0]    history;

    rps_match_scorer #(
        .WINS_TO_MATCH(WINS),
        .MAX_ROUNDS   (MAXR),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result       (result),
        .new_match    (new_match),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .tie_count    (tie_count),
        .round_count  (round_count),
        .invalid_count(invalid_count),
        .round_done   (round_done),
        .match_over   (match_over),
        .match_winner (match_winner),
        .history      (history)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integers, one call per clock edge.
    int m_p1, m_p2, m_tie, m_rounds, m_inv, m_rd, m_over, m_win, m_hist;

    task automatic model_clear();
        m_p1 = 0; m_p2 = 0; m_tie = 0; m_rounds = 0; m_inv = 0;
        m_rd = 0; m_over = 0; m_win = 0; m_hist = 0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] r, input logic nm);
        m_rd = 0;
        if (nm) begin
            model_clear();
        end else if (v && !m_over) begin
            if (r == 2'b11) begin
                if (m_inv < (1 << CW) - 1) m_inv++;
            end else begin
                if (r == 2'b01) m_p1++;
                else if (r == 2'b10) m_p2++;
                else m_tie++;
                m_rounds++;
                m_rd = 1;
                m_hist = ((m_hist << 2) | int'(r)) & 8'hff;
                if (m_p1 == WINS) begin
                    m_over = 1; m_win = 1;
                end else if (m_p2 == WINS) begin
                    m_over = 1; m_win = 2;
                end else if (m_rounds == MAXR) begin
                    m_over = 1;
                    m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_hist();
`ifdef RPS_HISTORY_EN
        return 8'(m_hist);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [31:0] dut_vec();
        return {p1_score, p2_score, tie_count, round_count, invalid_count,
                round_done, match_over, match_winner, history};
    endfunction

    function automatic logic [31:0] model_vec();
        return {4'(m_p1), 4'(m_p2), 4'(m_tie), 4'(m_rounds), 4'(m_inv),
                1'(m_rd), 1'(m_over), 2'(m_win), exp_hist()};
    endfunction

    // Drive one cycle of inputs, sample just after the edge, advance the model.
    task automatic drive(input logic v, input logic [1:0] r, input logic nm);
        @(negedge clk);
        result_valid = v;
        result       = r;
        new_match    = nm;
        @(posedge clk);
        #1;
        result_valid = 1'b0;
        new_match    = 1'b0;
        model_step(v, r, nm);
    endtask

    task automatic test_reset();
        rst = 1'b1; result_valid = 1'b0; result = 2'b00; new_match = 1'b0;
        model_clear();
        #22;
        n_cmp++;
        if (dut_vec() !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_p1_sweep();
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 1'b0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL p1_sweep_step%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if ({p1_score, round_count, match_over, match_winner} !== {4'd3, 4'd3, 1'b1, 2'b01}) begin
            n_bad++;
            $display("FAIL p1_sweep_final: got p1=%0d rounds=%0d over=%b win=%b expected 3 3 1 01",
                     p1_score, round_count, match_over, match_winner);
        end
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        n_cmp++;
        if ({p2_score, invalid_count, round_done, match_over} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL done_ignores: got p2=%0d inv=%0d rd=%b over=%b expected 0 0 0 1",
                     p2_score, invalid_count, round_done, match_over);
        end
    endtask

    task automatic test_round_limit();
        logic [1:0] seq [5] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL round_limit_step%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if ({round_count, p2_score, p1_score, tie_count, match_over, match_winner}
            !== {4'd5, 4'd2, 4'd1, 4'd2, 1'b1, 2'b10}) begin
            n_bad++;
            $display("FAIL round_limit_final: got r=%0d p2=%0d p1=%0d t=%0d over=%b win=%b",
                     round_count, p2_score, p1_score, tie_count, match_over, match_winner);
        end
    endtask

    task automatic test_draw();
        logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 1'b0);
        n_cmp++;
        if ({round_count, match_over, match_winner} !== {4'd5, 1'b1, 2'b00}) begin
            n_bad++;
            $display("FAIL draw_final: got r=%0d over=%b win=%b expected 5 1 00",
                     round_count, match_over, match_winner);
        end
    endtask

    task automatic test_invalid_idle();
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b11, 1'b0);
            n_cmp++;
            if ({round_done, round_count, invalid_count} !== {1'b0, 4'd0, 4'(i + 1)}) begin
                n_bad++;
                $display("FAIL invalid_idle_step%0d: got rd=%b r=%0d inv=%0d expected 0 0 %0d",
                         i, round_done, round_count, invalid_count, i + 1);
            end
        end
        drive(1'b1, 2'b01, 1'b0);
        n_cmp++;
        if ({round_done, round_count, invalid_count, match_over} !== {1'b1, 4'd1, 4'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL invalid_then_p1: got rd=%b r=%0d inv=%0d over=%b expected 1 1 2 0",
                     round_done, round_count, invalid_count, match_over);
        end
        drive(1'b0, 2'b00, 1'b0);
        n_cmp++;
        if (round_done !== 1'b0) begin
            n_bad++;
            $display("FAIL round_done_pulse: got %b expected 0", round_done);
        end
    endtask

    task automatic test_invalid_sat();
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 2'b11, 1'b0);
        n_cmp++;
        if (invalid_count !== 4'hf) begin
            n_bad++;
            $display("FAIL invalid_saturate: got %0d expected 15", invalid_count);
        end
    endtask

    task automatic test_new_match();
        drive(1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b1);
        n_cmp++;
        if (dut_vec() !== 32'h0) begin
            n_bad++;
            $display("FAIL new_match_wins: got %h expected %h", dut_vec(), 32'h0);
        end
        drive(1'b1, 2'b10, 1'b0);
        n_cmp++;
        if ({p2_score, round_count, round_done} !== {4'd1, 4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL new_match_restart: got p2=%0d r=%0d rd=%b expected 1 1 1",
                     p2_score, round_count, round_done);
        end
    endtask

    task automatic test_history();
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b00, 2'b01};
        logic [7:0] want;
`ifdef RPS_HISTORY_EN
        want = 8'h61;
`else
        want = 8'h00;
`endif
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        n_cmp++;
        if (history !== want) begin
            n_bad++;
            $display("FAIL history: got %h expected %h", history, want);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        n_cmp++;
        if (dut_vec() !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic       v, nm;
        logic [1:0] r;
        drive(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = 2'($urandom_range(0, 3));
            nm = ($urandom_range(0, 11) == 0);
            drive(v, r, nm);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random_step%0d: got %h expected %h (v=%b r=%b nm=%b)",
                         i, dut_vec(), model_vec(), v, r, nm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_p1_sweep();
        test_round_limit();
        test_draw();
        test_invalid_idle();
        test_invalid_sat();
        test_new_match();
        test_history();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
